// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the vector ALU sequencer and its op decoder.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, FADD, FSUB, MUL, FMUL, AND, OR, XOR, NOT,
        CMP_EQ, CMP_NE, CMP_LT, CMP_GE
    } op_e;

    typedef enum logic [1:0] {
        IDLE, ISSUE, DRAIN, DONE
    } state_e;

    // ALU output-select codes; OUT_INVALID marks an undecodable op
    localparam logic [2:0] OUT_ADDSUB  = 3'b000;
    localparam logic [2:0] OUT_FPADD   = 3'b001;
    localparam logic [2:0] OUT_MUL     = 3'b010;
    localparam logic [2:0] OUT_FPMUL   = 3'b011;
    localparam logic [2:0] OUT_BITWISE = 3'b100;
    localparam logic [2:0] OUT_INVALID = 3'b111;

    localparam logic [1:0] BW_AND = 2'b00;
    localparam logic [1:0] BW_OR  = 2'b01;
    localparam logic [1:0] BW_XOR = 2'b10;
    localparam logic [1:0] BW_NOT = 2'b11;

    localparam logic [1:0] CC_EQ = 2'b00;
    localparam logic [1:0] CC_NE = 2'b01;
    localparam logic [1:0] CC_LT = 2'b10;
    localparam logic [1:0] CC_GE = 2'b11;

    function automatic logic is_cmp(input op_e op);
        return (op == CMP_EQ) || (op == CMP_NE) || (op == CMP_LT) || (op == CMP_GE);
    endfunction

endpackage

// File: rtl/alu_vector_sequencer_decoder.sv
// Combinational decode of a vector op into the shared ALU control fields.
module alu_op_decoder
    import alu_seq_pkg::*;
(
    input  op_e        op,
    output logic       addsub,
    output logic [2:0] out_ctrl,
    output logic [1:0] bitwise_ctrl,
    output logic [1:0] comp_ctrl,
    output logic       cmp
);

    // Compares run through the subtract path; unknown codes select OUT_INVALID
    always_comb begin
        addsub       = 1'b0;
        out_ctrl     = OUT_INVALID;
        bitwise_ctrl = BW_AND;
        comp_ctrl    = CC_EQ;
        cmp          = is_cmp(op);
        case (op)
            ADD:    out_ctrl = OUT_ADDSUB;
            SUB:    begin out_ctrl = OUT_ADDSUB; addsub = 1'b1; end
            FADD:   out_ctrl = OUT_FPADD;
            FSUB:   begin out_ctrl = OUT_FPADD; addsub = 1'b1; end
            MUL:    out_ctrl = OUT_MUL;
            FMUL:   out_ctrl = OUT_FPMUL;
            AND:    begin out_ctrl = OUT_BITWISE; bitwise_ctrl = BW_AND; end
            OR:     begin out_ctrl = OUT_BITWISE; bitwise_ctrl = BW_OR; end
            XOR:    begin out_ctrl = OUT_BITWISE; bitwise_ctrl = BW_XOR; end
            NOT:    begin out_ctrl = OUT_BITWISE; bitwise_ctrl = BW_NOT; end
            CMP_EQ: begin out_ctrl = OUT_ADDSUB; addsub = 1'b1; comp_ctrl = CC_EQ; end
            CMP_NE: begin out_ctrl = OUT_ADDSUB; addsub = 1'b1; comp_ctrl = CC_NE; end
            CMP_LT: begin out_ctrl = OUT_ADDSUB; addsub = 1'b1; comp_ctrl = CC_LT; end
            CMP_GE: begin out_ctrl = OUT_ADDSUB; addsub = 1'b1; comp_ctrl = CC_GE; end
            default: out_ctrl = OUT_INVALID;
        endcase
    end

endmodule

// File: rtl/alu_vector_sequencer.sv
// Sequences one vector instruction at a time over the shared single-element ALU.
// Handshake: an instruction transfers on a cycle where instr_valid && instr_ready;
// instr_ready is high only in IDLE, so instructions never overlap.
// Pipeline: element read (ISSUE) -> ALU / writeback-register stage -> rf write.
module alu_vector_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int VLEN_MAX = 32,
    parameter int ADDR_W   = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [3:0]                  instr_op,
    input  logic [$clog2(VLEN_MAX):0]   instr_vl,
    input  logic [ADDR_W-1:0]           instr_vd,
    input  logic [ADDR_W-1:0]           instr_vs1,
    input  logic [ADDR_W-1:0]           instr_vs2,
    input  logic [ADDR_W-1:0]           instr_vs3,
    input  logic                        instr_use_c,
    input  logic                        instr_masked,
    output logic                        rf_re,
    output logic [ADDR_W-1:0]           rf_raddr_a,
    output logic [ADDR_W-1:0]           rf_raddr_b,
    output logic [ADDR_W-1:0]           rf_raddr_c,
    input  logic [WIDTH-1:0]            rf_rdata_a,
    input  logic [WIDTH-1:0]            rf_rdata_b,
    input  logic [WIDTH-1:0]            rf_rdata_c,
    output logic [WIDTH-1:0]            alu_a,
    output logic [WIDTH-1:0]            alu_b,
    output logic [WIDTH-1:0]            alu_c,
    output logic                        alu_addsub,
    output logic                        alu_mux_ctrl,
    output logic [2:0]                  alu_out_ctrl,
    output logic [1:0]                  alu_bitwise_ctrl,
    output logic [1:0]                  alu_comp_ctrl,
    input  logic [WIDTH-1:0]            alu_result,
    input  logic                        alu_predicate,
    output logic                        rf_we,
    output logic [ADDR_W-1:0]           rf_waddr,
    output logic [WIDTH-1:0]            rf_wdata,
    output logic [VLEN_MAX-1:0]         mask_q,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  state_dbg
);

    localparam int CNT_W = $clog2(VLEN_MAX) + 1;
    localparam int IDX_W = $clog2(VLEN_MAX);

    state_e             state, state_n;
    op_e                op_q;
    logic [CNT_W-1:0]   vl_q, idx, vl_eff;
    logic [ADDR_W-1:0]  vd_q, vs1_q, vs2_q, vs3_q;
    logic               use_c_q, masked_q;
    logic               s2_valid;
    logic [IDX_W-1:0]   idx_d;
    logic               accept, dec_cmp, write_ok;

    assign accept = instr_valid && instr_ready;
    assign vl_eff = (instr_vl > CNT_W'(VLEN_MAX)) ? CNT_W'(VLEN_MAX) : instr_vl;

    alu_op_decoder u_dec (
        .op           (op_q),
        .addsub       (alu_addsub),
        .out_ctrl     (alu_out_ctrl),
        .bitwise_ctrl (alu_bitwise_ctrl),
        .comp_ctrl    (alu_comp_ctrl),
        .cmp          (dec_cmp)
    );

    assign rf_raddr_a   = vs1_q + ADDR_W'(idx);
    assign rf_raddr_b   = vs2_q + ADDR_W'(idx);
    assign rf_raddr_c   = vs3_q + ADDR_W'(idx);
    assign alu_a        = rf_rdata_a;
    assign alu_b        = rf_rdata_b;
    assign alu_c        = rf_rdata_c;
    assign alu_mux_ctrl = use_c_q;
    assign state_dbg    = state;
    // A masked element is suppressed when its current mask bit is clear
    assign write_ok     = !(masked_q && !mask_q[idx_d]);

    // Next-state and FSM-derived strobes
    always_comb begin
        state_n     = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        rf_re       = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (accept) state_n = (vl_eff == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                rf_re = 1'b1;
                if (idx == vl_q - CNT_W'(1)) state_n = DRAIN;
            end
            DRAIN:   state_n = DONE;
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, instruction latch and element index pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            idx_d    <= '0;
            s2_valid <= 1'b0;
            op_q     <= ADD;
            vl_q     <= '0;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vs3_q    <= '0;
            use_c_q  <= 1'b0;
            masked_q <= 1'b0;
        end else begin
            state    <= state_n;
            s2_valid <= (state == ISSUE);
            idx_d    <= idx[IDX_W-1:0];
            if (accept) begin
                idx      <= '0;
                op_q     <= op_e'(instr_op);
                vl_q     <= vl_eff;
                vd_q     <= instr_vd;
                vs1_q    <= instr_vs1;
                vs2_q    <= instr_vs2;
                vs3_q    <= instr_vs3;
                use_c_q  <= instr_use_c;
                masked_q <= instr_masked;
            end else if (state == ISSUE) begin
                idx <= idx + CNT_W'(1);
            end
        end
    end

    // Stage 2: register the write or fold the compare predicate into the mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            mask_q   <= '1;
        end else begin
            rf_we <= 1'b0;
            if (s2_valid) begin
                if (dec_cmp) begin
                    if (write_ok) mask_q[idx_d] <= alu_predicate;
                end else begin
                    rf_we    <= write_ok;
                    rf_waddr <= vd_q + ADDR_W'(idx_d);
                    rf_wdata <= (alu_out_ctrl == OUT_INVALID) ? '0 : alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Directed table-driven bench for alu_vector_sequencer with a register-file
// and stub-ALU environment plus hand-written reset-abort sequence.
module tb_alu_vector_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [5:0]  instr_vl = '0;
    logic [5:0]  instr_vd = '0, instr_vs1 = '0, instr_vs2 = '0, instr_vs3 = '0;
    logic        instr_use_c = 1'b0, instr_masked = 1'b0;
    logic        rf_re;
    logic [5:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c;
    logic [31:0] rf_rdata_a = '0, rf_rdata_b = '0, rf_rdata_c = '0;
    logic [31:0] alu_a, alu_b, alu_c;
    logic        alu_addsub, alu_mux_ctrl;
    logic [2:0]  alu_out_ctrl;
    logic [1:0]  alu_bitwise_ctrl, alu_comp_ctrl;
    logic [31:0] alu_result;
    logic        alu_predicate;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] mask_q;
    logic        busy, done;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad = 0;

    alu_vector_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_vl(instr_vl),
        .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vs3(instr_vs3),
        .instr_use_c(instr_use_c), .instr_masked(instr_masked),
        .rf_re(rf_re), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_raddr_c(rf_raddr_c),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_rdata_c(rf_rdata_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_addsub(alu_addsub), .alu_mux_ctrl(alu_mux_ctrl), .alu_out_ctrl(alu_out_ctrl),
        .alu_bitwise_ctrl(alu_bitwise_ctrl), .alu_comp_ctrl(alu_comp_ctrl),
        .alu_result(alu_result), .alu_predicate(alu_predicate),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mask_q(mask_q), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // register file: data valid the cycle after rf_re
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (rf_re) begin
            rf_rdata_a <= mem[rf_raddr_a];
            rf_rdata_b <= mem[rf_raddr_b];
            rf_rdata_c <= mem[rf_raddr_c];
        end
    end

    // stub ALU: FP paths are tagged with bit 31 so path selection is visible
    logic [31:0] opb, sum;
    always_comb begin
        opb = alu_mux_ctrl ? alu_c : alu_b;
        sum = alu_addsub ? (alu_a - opb) : (alu_a + opb);
        case (alu_out_ctrl)
            3'b000: alu_result = sum;
            3'b001: alu_result = sum ^ 32'h8000_0000;
            3'b010: alu_result = alu_a * opb;
            3'b011: alu_result = (alu_a * opb) ^ 32'h8000_0000;
            3'b100: begin
                case (alu_bitwise_ctrl)
                    2'b00: alu_result = alu_a & opb;
                    2'b01: alu_result = alu_a | opb;
                    2'b10: alu_result = alu_a ^ opb;
                    default: alu_result = ~alu_a;
                endcase
            end
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        case (alu_comp_ctrl)
            2'b00: alu_predicate = (alu_a == opb);
            2'b01: alu_predicate = (alu_a != opb);
            2'b10: alu_predicate = (alu_a < opb);
            default: alu_predicate = (alu_a >= opb);
        endcase
    end

    // monitor: logs writes, reads and done pulses
    logic [5:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [5:0]  ra_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int idle_we = 0;
    always @(negedge clk) begin
        if (rf_we) begin
            wa_q.push_back(rf_waddr);
            wd_q.push_back(rf_wdata);
            wc_q.push_back(cyc);
        end
        if (rf_re) ra_q.push_back(rf_raddr_a);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rf_we && instr_ready) idle_we++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        int          vl, vd, vs1, vs2, vs3;
        logic        use_c, masked;
        logic [31:0] a0, a_step, a_odd, b0, c0;
        int          e_cnt, e_fa, e_la;
        logic [31:0] e_fd, e_ld;
        int          e_fra, e_lra;
        logic [31:0] e_mask;
        int          e_lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic setup_rf(input vec_t v, input int n);
        for (int i = 0; i < n; i++) mem[6'(v.vs2 + i)] = v.b0;
        for (int i = 0; i < n; i++) mem[6'(v.vs3 + i)] = v.c0;
        for (int i = 0; i < n; i++)
            mem[6'(v.vs1 + i)] = v.a0 + 32'(i) * v.a_step + ((i % 2 == 1) ? v.a_odd : 32'd0);
    endtask

    task automatic drive(input vec_t v);
        instr_op     = v.op;
        instr_vl     = 6'(v.vl);
        instr_vd     = 6'(v.vd);
        instr_vs1    = 6'(v.vs1);
        instr_vs2    = 6'(v.vs2);
        instr_vs3    = 6'(v.vs3);
        instr_use_c  = v.use_c;
        instr_masked = v.masked;
        instr_valid  = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int vle, acc, w0, r0, d0, k, nw;
        string t;
        t = $sformatf("v%0d", n);
        vle = (v.vl > 32) ? 32 : v.vl;
        setup_rf(v, vle);
        @(negedge clk); #1;
        w0 = wa_q.size(); r0 = ra_q.size(); d0 = done_cnt;
        chk({t, "_ready"}, 32'(instr_ready), 32'd1);
        drive(v);
        acc = cyc;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_cnt == d0) chk({t, "_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        #1;
        nw = wa_q.size() - w0;
        chk({t, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({t, "_latency"}, 32'(done_cyc - acc), 32'(v.e_lat));
        chk({t, "_nwrites"}, 32'(nw), 32'(v.e_cnt));
        chk({t, "_nreads"}, 32'(ra_q.size() - r0), 32'(vle));
        chk({t, "_mask"}, mask_q, v.e_mask);
        if (vle > 0) begin
            chk({t, "_raddr_first"}, 32'(ra_q[r0]), 32'(v.e_fra));
            chk({t, "_raddr_last"}, 32'(ra_q[ra_q.size()-1]), 32'(v.e_lra));
        end
        if (nw > 0) begin
            chk({t, "_waddr_first"}, 32'(wa_q[w0]), 32'(v.e_fa));
            chk({t, "_waddr_last"}, 32'(wa_q[wa_q.size()-1]), 32'(v.e_la));
            chk({t, "_wdata_first"}, wd_q[w0], v.e_fd);
            chk({t, "_wdata_last"}, wd_q[wd_q.size()-1], v.e_ld);
            chk({t, "_wlat_first"}, 32'(wc_q[w0] - acc), 32'd3);
            if (!v.masked)
                chk({t, "_wspan"}, 32'(wc_q[wc_q.size()-1] - wc_q[w0]), 32'(nw - 1));
        end
    endtask

    initial begin
        int w_snap, d_snap, r0, w0, k;
        vec_t rv;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);

        //            op      vl vd vs1 vs2 vs3 c  m  a0            step   odd    b0            c0        cnt fa la fd            ld            fra lra mask           lat
        vecs[0]  = '{ADD,     4, 16, 0, 8, 40, 0, 0, 32'd1,        32'd1, 32'd0, 32'd10,       32'd0,    4, 16, 19, 32'd11,       32'd14,       0, 3, 32'hFFFF_FFFF, 6};
        vecs[1]  = '{SUB,     3, 16, 0, 8, 40, 0, 0, 32'd20,       32'd5, 32'd0, 32'd7,        32'd0,    3, 16, 18, 32'd13,       32'd23,       0, 2, 32'hFFFF_FFFF, 5};
        vecs[2]  = '{AND,     2, 16, 0, 8, 40, 0, 0, 32'hF0,       32'hF, 32'd0, 32'h3C,       32'd0,    2, 16, 17, 32'h30,       32'h3C,       0, 1, 32'hFFFF_FFFF, 4};
        vecs[3]  = '{XOR,     3, 20, 4, 8, 40, 0, 0, 32'hFF,       32'd1, 32'd0, 32'h0F,       32'd0,    3, 20, 22, 32'hF0,       32'h10E,      4, 6, 32'hFFFF_FFFF, 5};
        vecs[4]  = '{MUL,     2, 16, 0, 8, 40, 0, 0, 32'd3,        32'd1, 32'd0, 32'd6,        32'd0,    2, 16, 17, 32'd18,       32'd24,       0, 1, 32'hFFFF_FFFF, 4};
        vecs[5]  = '{ADD,     2, 16, 0, 8, 40, 1, 0, 32'd1,        32'd1, 32'd0, 32'd100,      32'd1000, 2, 16, 17, 32'd1001,     32'd1002,     0, 1, 32'hFFFF_FFFF, 4};
        vecs[6]  = '{FSUB,    2, 16, 0, 8, 40, 0, 0, 32'd10,       32'd1, 32'd0, 32'd3,        32'd0,    2, 16, 17, 32'h8000_0007, 32'h8000_0008, 0, 1, 32'hFFFF_FFFF, 4};
        vecs[7]  = '{FMUL,    1, 16, 0, 8, 40, 0, 0, 32'd3,        32'd0, 32'd0, 32'd5,        32'd0,    1, 16, 16, 32'h8000_000F, 32'h8000_000F, 0, 0, 32'hFFFF_FFFF, 3};
        vecs[8]  = '{OR,      1, 16, 0, 8, 40, 0, 0, 32'hA0,       32'd0, 32'd0, 32'h05,       32'd0,    1, 16, 16, 32'hA5,       32'hA5,       0, 0, 32'hFFFF_FFFF, 3};
        vecs[9]  = '{NOT,     1, 16, 0, 8, 40, 0, 0, 32'h0F,       32'd0, 32'd0, 32'd0,        32'd0,    1, 16, 16, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 0, 32'hFFFF_FFFF, 3};
        vecs[10] = '{FADD,    1, 16, 0, 8, 40, 0, 0, 32'd2,        32'd0, 32'd0, 32'd3,        32'd0,    1, 16, 16, 32'h8000_0005, 32'h8000_0005, 0, 0, 32'hFFFF_FFFF, 3};
        vecs[11] = '{4'd15,   2, 16, 0, 8, 40, 0, 0, 32'd1,        32'd1, 32'd0, 32'd3,        32'd0,    2, 16, 17, 32'd0,        32'd0,        0, 1, 32'hFFFF_FFFF, 4};
        vecs[12] = '{CMP_LT,  3, 16, 0, 8, 40, 0, 0, 32'd1,        32'd4, 32'd0, 32'd5,        32'd0,    0, 0,  0,  32'd0,        32'd0,        0, 2, 32'hFFFF_FFF9, 5};
        vecs[13] = '{CMP_EQ,  4, 16, 0, 8, 40, 0, 0, 32'd5,        32'd0, 32'd1, 32'd5,        32'd0,    0, 0,  0,  32'd0,        32'd0,        0, 3, 32'hFFFF_FFF5, 6};
        vecs[14] = '{SUB,     4, 16, 0, 8, 40, 0, 1, 32'd10,       32'd1, 32'd0, 32'd1,        32'd0,    2, 16, 18, 32'd9,        32'd11,       0, 3, 32'hFFFF_FFF5, 6};
        vecs[15] = '{CMP_GE,  4, 16, 0, 8, 40, 0, 1, 32'd0,        32'd1, 32'd0, 32'd2,        32'd0,    0, 0,  0,  32'd0,        32'd0,        0, 3, 32'hFFFF_FFF4, 6};
        vecs[16] = '{ADD,     0, 16, 0, 8, 40, 0, 0, 32'd1,        32'd1, 32'd0, 32'd1,        32'd0,    0, 0,  0,  32'd0,        32'd0,        0, 0, 32'hFFFF_FFF4, 1};
        vecs[17] = '{ADD,     4, 16, 62, 8, 40, 0, 0, 32'd1,       32'd1, 32'd0, 32'd10,       32'd0,    4, 16, 19, 32'd11,       32'd14,       62, 1, 32'hFFFF_FFF4, 6};
        vecs[18] = '{ADD,    40, 32, 0, 0, 40, 0, 0, 32'd0,        32'd1, 32'd0, 32'd0,        32'd0,    32, 32, 63, 32'd0,       32'd62,       0, 31, 32'hFFFF_FFF4, 34};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_re", 32'(rf_re), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_mask", mask_q, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // reset asserted while element 2 of a vl=8 ADD is being read
        rv = vecs[0];
        rv.vl = 8;
        setup_rf(rv, 8);
        @(negedge clk); #1;
        r0 = ra_q.size(); w0 = wa_q.size(); d_snap = done_cnt;
        drive(rv);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        k = 0;
        while ((ra_q.size() - r0) < 3 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("abort_reached_elem2", 32'(ra_q.size() - r0), 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_in_reset", 32'(busy), 32'd0);
        chk("abort_we_in_reset", 32'(rf_we), 32'd0);
        w_snap = wa_q.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("abort_ready_after", 32'(instr_ready), 32'd1);
        chk("abort_mask", mask_q, 32'hFFFF_FFFF);
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_more_writes", 32'(wa_q.size() - w_snap), 32'd0);
        chk("abort_writes_total", 32'(wa_q.size() - w0), 32'd1);
        chk("abort_no_done", 32'(done_cnt - d_snap), 32'd0);
        chk("idle_we", 32'(idle_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
- Accepts one vector ALU instruction per valid/ready handshake.
- Sequences the shared single-element ALU over vl elements: issues element reads, drives the ALU control fields, writes results back, and records compare predicates into a mask register.
- Sits between the vector instruction decoder and the vector register file / ALU pair in the coprocessor lane.

Parameters:
WIDTH, 32, element/ALU data width
VLEN_MAX, 32, maximum elements per instruction
ADDR_W, 6, register-file element address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
instr_op  in  4  operation code (package enum)
instr_vl  in  $clog2(VLEN_MAX)+1  element count
instr_vd / instr_vs1 / instr_vs2 / instr_vs3  in  ADDR_W each  base element addresses
instr_use_c  in  1  select operand C (vs3 stream) instead of B
instr_masked  in  1  suppress writes where mask_q[idx]==0
rf_re  out  1  read strobe
rf_raddr_a / rf_raddr_b / rf_raddr_c  out  ADDR_W each  read addresses
rf_rdata_a / rf_rdata_b / rf_rdata_c  in  WIDTH each  read data, valid 1 cycle after rf_re
alu_a / alu_b / alu_c  out  WIDTH each  ALU operands (= rf_rdata, passed through)
alu_addsub, alu_mux_ctrl  out  1 each  ALU controls
alu_out_ctrl  out  3  ALU output select
alu_bitwise_ctrl, alu_comp_ctrl  out  2 each  ALU controls
alu_result  in  WIDTH  ALU result
alu_predicate  in  1  ALU compare result
rf_we  out  1  write strobe (registered)
rf_waddr  out  ADDR_W  write address (registered)
rf_wdata  out  WIDTH  write data (registered)
mask_q  out  VLEN_MAX  predicate/mask register
busy  out  1  not IDLE
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset, synchronous while rst_n==0: state=IDLE; rf_re, rf_we and done are 0; rf_waddr and rf_wdata are 0; mask_q is all 1s; the element index is 0.
- Accept: handshake occurs when instr_valid && instr_ready. All instr_* fields are latched. vl_eff = min(instr_vl, VLEN_MAX).
- States:
  - IDLE -> ISSUE on accept with vl_eff>0. IDLE -> DONE on accept with vl_eff==0 (no reads, no writes).
  - ISSUE: one element per cycle. rf_re=1; raddr_x = base_x + idx, modulo 2^ADDR_W (wrap, no error). idx increments each cycle. When idx==vl_eff-1 -> DRAIN.
  - DRAIN: one cycle, writes back the final element -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Element stage 2 (the cycle after its read):
  - ALU controls are decoded combinationally from the latched op. alu_mux_ctrl = latched use_c.
  - ALU-write ops: rf_we <= !(masked && !mask_q[idx_d]); rf_waddr <= vd + idx_d; rf_wdata <= alu_result. The write appears 2 cycles after that element's read.
  - Compare ops (CMP_*): rf_we stays 0; mask_q[idx_d] <= alu_predicate. Only bits 0..vl_eff-1 are modified.
  - Masked compare: the bit is updated only when the old mask bit is 1.
- Throughput and latency: vl_eff elements take vl_eff+2 cycles from accept to the done pulse (accept cycle excluded). instr_ready=0 from accept until back in IDLE, so there is no overlap between instructions.
- Ops with alu_out_ctrl==default (invalid op): writes are performed with data 0. Never a hang.
- Reset mid-operation aborts immediately: no further rf_we, no done pulse, mask_q is restored to all 1s.
- Only one rf_we pulse per element; rf_we is never asserted in IDLE.

Decomposition:
- Package alu_seq_pkg:
  - op_e enum: ADD, SUB, FADD, FSUB, MUL, FMUL, AND, OR, XOR, NOT, CMP_EQ, CMP_NE, CMP_LT, CMP_GE.
  - state_e: IDLE, ISSUE, DRAIN, DONE.
  - OUT_ADDSUB=3'b000, OUT_FPADD=3'b001, OUT_MUL=3'b010, OUT_FPMUL=3'b011, OUT_BITWISE=3'b100.
  - Bitwise codes: AND=00, OR=01, XOR=10, NOT=11. Compare codes: EQ=00, NE=01, LT=10, GE=11.
  - A function is_cmp(op).
- One sub-module: alu_op_decoder, combinational op_e -> {addsub, out_ctrl, bitwise_ctrl, comp_ctrl, is_cmp}.

Test Plan:
- ADD, vl=4, vs1=0, vs2=8, vd=16, rf[0..3]=1..4, rf[8..11]=10: writes 11,12,13,14 to addresses 16..19 on consecutive cycles; done pulses 6 cycles after accept.
- CMP_LT, vl=3, A={1,5,9}, B=5: mask_q[2:0]=3'b001; remaining bits stay 1; no rf_we.
- Masked SUB, mask_q=...0101, vl=4: writes only to vd+0 and vd+2.
- vl=0: done pulses the cycle after accept, with zero rf_re and zero rf_we; vl=40 is clamped to 32 writes.
- Wrap, vs1=62, vl=4 (ADDR_W=6): read addresses 62, 63, 0, 1.
- rst_n=0 asserted at element 2 of vl=8: no further writes, no done, instr_ready=1 in the cycle after release, mask_q all 1s.
